// File: rtl/dac_seq_pkg.sv
// Shared encodings for the DAC sweep sequencer: sweep modes, FSM states, triangle direction.
// Optional oscillator frequency counter is enabled with OSC_FREQ_CNT_EN.
package dac_seq_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/dac_osc_freq_counter.sv
// Counts synchronised oscillator rising edges per dwell; result latched at dwell end.
// Latency: 2-FF synchroniser plus edge register; freq_cnt/freq_valid registered.
// Backpressure: none; frozen while ena=0, count cleared while no sweep runs.
module dac_osc_freq_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             run,
    input  logic             dwell_end,
    input  logic             osc_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_valid
);

    logic             sync1, sync2, sync3;
    logic             rise;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign rise    = sync2 & ~sync3;
    assign cnt_nxt = (rise && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            cnt        <= '0;
            freq_cnt   <= '0;
            freq_valid <= 1'b0;
        end else if (ena) begin
            sync1      <= osc_in;
            sync2      <= sync1;
            sync3      <= sync2;
            freq_valid <= 1'b0;
            if (dwell_end) begin
                freq_cnt   <= cnt_nxt;
                freq_valid <= 1'b1;
                cnt        <= '0;
            end else if (!run) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/dac_sweep_sequencer.sv
// DAC sweep sequencer (HOLD/RAMP/TRIANGLE/TOGGLE), code held div+1 cycles; OSC_FREQ_CNT_EN adds freq counter.
// Latency: first code one cycle after an accepted start; each code visible div+1 enabled cycles.
// Backpressure: ena=0 freezes all state and outputs; stop aborts on the next edge.
module dac_sweep_sequencer
    import dac_seq_pkg::*;
#(
    parameter int DAC_W = 8,
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [DAC_W-1:0] code_lo,
    input  logic [DAC_W-1:0] code_hi,
    input  logic [DAC_W-1:0] step,
    input  logic [DIV_W-1:0] div,
    input  logic             osc_in,
    output logic [DAC_W-1:0] dac_code,
    output logic             dac_update,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_valid
);

    state_t           state;
    logic [1:0]       mode_l;
    logic [DAC_W-1:0] lo_l, hi_l, step_l;
    logic [DIV_W-1:0] div_l, cnt;
    logic             dir;

    logic [DAC_W:0]   sum, diff;
    logic [DAC_W-1:0] up_code, dn_code, nxt_code;
    logic             nxt_dir, ramp_end;

    // STEP is the last cycle of a dwell, so DWELL itself runs div cycles.
    always_comb begin
        sum      = {1'b0, dac_code} + {1'b0, step_l};
        diff     = {1'b0, dac_code} - {1'b0, step_l};
        up_code  = (sum > {1'b0, hi_l}) ? hi_l : sum[DAC_W-1:0];
        dn_code  = (diff[DAC_W] || (diff[DAC_W-1:0] < lo_l)) ? lo_l : diff[DAC_W-1:0];
        nxt_code = dac_code;
        nxt_dir  = dir;
        ramp_end = 1'b0;
        case (mode_l)
            MODE_HOLD: nxt_code = lo_l;
            MODE_RAMP: begin
                if (dac_code == hi_l) ramp_end = 1'b1;
                else                  nxt_code = up_code;
            end
            MODE_TRI: begin
                if (dir == DIR_UP) begin
                    if (dac_code == hi_l) begin
                        nxt_dir  = DIR_DOWN;
                        nxt_code = dn_code;
                    end else begin
                        nxt_code = up_code;
                    end
                end else begin
                    if (dac_code == lo_l) begin
                        nxt_dir  = DIR_UP;
                        nxt_code = up_code;
                    end else begin
                        nxt_code = dn_code;
                    end
                end
            end
            default: nxt_code = (dac_code == lo_l) ? hi_l : lo_l;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mode_l     <= MODE_HOLD;
            lo_l       <= '0;
            hi_l       <= '0;
            step_l     <= '0;
            div_l      <= '0;
            cnt        <= '0;
            dir        <= DIR_UP;
            dac_code   <= '0;
            dac_update <= 1'b0;
            osc_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (ena) begin
            dac_update <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (code_lo > code_hi) begin
                            err <= 1'b1;
                        end else begin
                            mode_l     <= mode;
                            lo_l       <= code_lo;
                            hi_l       <= code_hi;
                            step_l     <= (step == '0) ? DAC_W'(1) : step;
                            div_l      <= div;
                            cnt        <= '0;
                            dir        <= DIR_UP;
                            dac_code   <= code_lo;
                            dac_update <= 1'b1;
                            osc_en     <= 1'b1;
                            busy       <= 1'b1;
                            state      <= (div == '0) ? ST_STEP : ST_DWELL;
                        end
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        osc_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (cnt + DIV_W'(1) == div_l) begin
                        state <= ST_STEP;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                ST_STEP: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        osc_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (ramp_end) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        osc_en <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        dac_code   <= nxt_code;
                        dac_update <= (nxt_code != dac_code);
                        dir        <= nxt_dir;
                        cnt        <= '0;
                        state      <= (div_l == '0) ? ST_STEP : ST_DWELL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef OSC_FREQ_CNT_EN
    logic dwell_end;
    assign dwell_end = (state == ST_STEP);

    dac_osc_freq_counter #(
        .CNT_W (CNT_W)
    ) u_freq_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .run        (busy),
        .dwell_end  (dwell_end),
        .osc_in     (osc_in),
        .freq_cnt   (freq_cnt),
        .freq_valid (freq_valid)
    );
`else
    logic unused_osc;
    assign unused_osc = osc_in;
    assign freq_cnt   = '0;
    assign freq_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Directed bench for dac_sweep_sequencer; expected code sequences are hand-computed per scenario.
module tb_dac_sweep_sequencer;
    import dac_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, ena, start, stop;
    logic [1:0]  mode;
    logic [7:0]  code_lo, code_hi, step;
    logic [15:0] div;
    logic        osc_in;
    logic [7:0]  dac_code;
    logic        dac_update, osc_en, busy, done, err;
    logic [15:0] freq_cnt;
    logic        freq_valid;

    int vecs = 0;
    int errs = 0;
    int upd_code[$];
    int upd_cyc[$];
    int fv_cyc[$];
    int fv_val[$];
    int done_cyc;
    bit osc_run = 1'b0;

    dac_sweep_sequencer #(.DAC_W(8), .DIV_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .code_lo    (code_lo),
        .code_hi    (code_hi),
        .step       (step),
        .div        (div),
        .osc_in     (osc_in),
        .dac_code   (dac_code),
        .dac_update (dac_update),
        .osc_en     (osc_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .freq_cnt   (freq_cnt),
        .freq_valid (freq_valid)
    );

    always #5 clk = ~clk;

    // Oscillator with a period of 8 clock cycles.
    initial begin
        osc_in = 1'b0;
        forever begin
            #40;
            if (osc_run) osc_in = ~osc_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [7:0] st, input logic [15:0] dv);
        mode    = m;
        code_lo = lo;
        code_hi = hi;
        step    = st;
        div     = dv;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    // Samples k = 0..n-1, starting at the current time.
    task automatic capture(input int n);
        upd_code.delete();
        upd_cyc.delete();
        fv_cyc.delete();
        fv_val.delete();
        done_cyc = -1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            if (dac_update === 1'b1) begin
                upd_code.push_back(int'(dac_code));
                upd_cyc.push_back(k);
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
            if (freq_valid === 1'b1) begin
                fv_cyc.push_back(k);
                fv_val.push_back(int'(freq_cnt));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
        mode = MODE_HOLD; code_lo = 8'd0; code_hi = 8'd0; step = 8'd0; div = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({dac_code, dac_update, osc_en, busy, done, err} !== 13'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %h required 0", {dac_code, dac_update, osc_en, busy, done, err});
        end
        vecs++;
        if ({freq_cnt, freq_valid} !== 17'd0) begin
            errs++;
            $display("FAIL reset_freq: got %h required 0", {freq_cnt, freq_valid});
        end
        #3 rst_n = 1'b1;
        tick(); tick();
        vecs++;
        if ({dac_code, busy, osc_en} !== 10'd0) begin
            errs++;
            $display("FAIL idle_after_reset: got %h required 0", {dac_code, busy, osc_en});
        end
    endtask

    task automatic test_ramp();
        int e_code[4] = '{10, 20, 30, 40};
        int e_cyc[4]  = '{0, 4, 8, 12};
        go(MODE_RAMP, 8'd10, 8'd40, 8'd10, 16'd3);
        vecs++;
        if (busy !== 1'b1 || osc_en !== 1'b1) begin
            errs++;
            $display("FAIL ramp_busy: got busy=%b osc_en=%b required 1 1", busy, osc_en);
        end
        capture(20);
        vecs++;
        if (upd_code.size() != 4) begin
            errs++;
            $display("FAIL ramp_updates: got %0d required 4", upd_code.size());
        end
        for (int i = 0; i < 4; i++) begin
            int gc, gk;
            gc = (i < upd_code.size()) ? upd_code[i] : -1;
            gk = (i < upd_cyc.size()) ? upd_cyc[i] : -1;
            vecs++;
            if (gc != e_code[i] || gk != e_cyc[i]) begin
                errs++;
                $display("FAIL ramp_code%0d: got %0d@%0d required %0d@%0d", i, gc, gk, e_code[i], e_cyc[i]);
            end
        end
        vecs++;
        if (done_cyc != 16) begin
            errs++;
            $display("FAIL ramp_done_cycle: got %0d required 16", done_cyc);
        end
        vecs++;
        if (busy !== 1'b0 || osc_en !== 1'b0 || dac_code !== 8'd40) begin
            errs++;
            $display("FAIL ramp_end_state: got busy=%b osc_en=%b code=%0d required 0 0 40", busy, osc_en, dac_code);
        end
        tick();
    endtask

    task automatic test_ramp_clamp();
        int e1[4] = '{0, 10, 20, 25};
        int e2[4] = '{3, 4, 5, 6};
        go(MODE_RAMP, 8'd0, 8'd25, 8'd10, 16'd0);
        capture(8);
        vecs++;
        if (upd_code.size() != 4 || done_cyc != 4) begin
            errs++;
            $display("FAIL clamp_count: got %0d updates done@%0d required 4 done@4", upd_code.size(), done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            int gc;
            gc = (i < upd_code.size()) ? upd_code[i] : -1;
            vecs++;
            if (gc != e1[i]) begin
                errs++;
                $display("FAIL clamp_code%0d: got %0d required %0d", i, gc, e1[i]);
            end
        end
        tick();
        go(MODE_RAMP, 8'd3, 8'd6, 8'd0, 16'd0);
        capture(8);
        for (int i = 0; i < 4; i++) begin
            int gc;
            gc = (i < upd_code.size()) ? upd_code[i] : -1;
            vecs++;
            if (gc != e2[i]) begin
                errs++;
                $display("FAIL step0_code%0d: got %0d required %0d", i, gc, e2[i]);
            end
        end
        vecs++;
        if (done_cyc != 4) begin
            errs++;
            $display("FAIL step0_done: got %0d required 4", done_cyc);
        end
        tick();
    endtask

    task automatic test_triangle_stop();
        int e_code[5] = '{5, 6, 7, 6, 5};
        go(MODE_TRI, 8'd5, 8'd7, 8'd1, 16'd1);
        capture(9);
        for (int i = 0; i < 5; i++) begin
            int gc, gk;
            gc = (i < upd_code.size()) ? upd_code[i] : -1;
            gk = (i < upd_cyc.size()) ? upd_cyc[i] : -1;
            vecs++;
            if (gc != e_code[i] || gk != 2 * i) begin
                errs++;
                $display("FAIL tri_code%0d: got %0d@%0d required %0d@%0d", i, gc, gk, e_code[i], 2 * i);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vecs++;
        if (busy !== 1'b0 || osc_en !== 1'b0 || dac_code !== 8'd5 || done !== 1'b0) begin
            errs++;
            $display("FAIL tri_stop: got busy=%b osc_en=%b code=%0d done=%b required 0 0 5 0", busy, osc_en, dac_code, done);
        end
        capture(4);
        vecs++;
        if (upd_code.size() != 0 || done_cyc != -1) begin
            errs++;
            $display("FAIL tri_after_stop: got %0d updates done@%0d required 0 none", upd_code.size(), done_cyc);
        end
    endtask

    task automatic test_toggle_hold();
        int e_code[4] = '{1, 200, 1, 200};
        go(MODE_TOGGLE, 8'd1, 8'd200, 8'd3, 16'd0);
        capture(4);
        for (int i = 0; i < 4; i++) begin
            int gc;
            gc = (i < upd_code.size()) ? upd_code[i] : -1;
            vecs++;
            if (gc != e_code[i]) begin
                errs++;
                $display("FAIL toggle_code%0d: got %0d required %0d", i, gc, e_code[i]);
            end
        end
        halt();
        go(MODE_HOLD, 8'd9, 8'd20, 8'd1, 16'd0);
        capture(6);
        vecs++;
        if (upd_code.size() != 1 || done_cyc != -1 || busy !== 1'b1 || dac_code !== 8'd9) begin
            errs++;
            $display("FAIL hold: got %0d updates done@%0d busy=%b code=%0d required 1 none 1 9",
                     upd_code.size(), done_cyc, busy, dac_code);
        end
        halt();
    endtask

    task automatic test_reject();
        go(MODE_RAMP, 8'd50, 8'd20, 8'd1, 16'd0);
        vecs++;
        if (err !== 1'b1 || busy !== 1'b0 || dac_code !== 8'd9 || dac_update !== 1'b0) begin
            errs++;
            $display("FAIL reject: got err=%b busy=%b code=%0d upd=%b required 1 0 9 0", err, busy, dac_code, dac_update);
        end
        tick();
        vecs++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL reject_pulse: got err=%b required 0", err);
        end
        stop = 1'b1;
        go(MODE_RAMP, 8'd10, 8'd20, 8'd1, 16'd0);
        stop = 1'b0;
        vecs++;
        if (busy !== 1'b0 || err !== 1'b0 || dac_update !== 1'b0 || dac_code !== 8'd9) begin
            errs++;
            $display("FAIL start_stop: got busy=%b err=%b upd=%b code=%0d required 0 0 0 9", busy, err, dac_update, dac_code);
        end
        tick();
    endtask

    task automatic test_ena_reset();
        go(MODE_RAMP, 8'd10, 8'd40, 8'd10, 16'd3);
        tick();
        ena = 1'b0;
        repeat (5) tick();
        vecs++;
        if (dac_code !== 8'd10 || busy !== 1'b1 || dac_update !== 1'b0) begin
            errs++;
            $display("FAIL ena_hold: got code=%0d busy=%b upd=%b required 10 1 0", dac_code, busy, dac_update);
        end
        ena = 1'b1;
        capture(5);
        vecs++;
        if (upd_cyc.size() != 1 || upd_cyc[0] != 3 || upd_code[0] != 20) begin
            errs++;
            $display("FAIL ena_extend: got %0d updates first=%0d@%0d required 20@3",
                     upd_cyc.size(), (upd_code.size() > 0) ? upd_code[0] : -1, (upd_cyc.size() > 0) ? upd_cyc[0] : -1);
        end
        rst_n = 1'b0;
        #2;
        vecs++;
        if ({dac_code, dac_update, osc_en, busy, done, err} !== 13'd0) begin
            errs++;
            $display("FAIL async_reset: got %h required 0", {dac_code, dac_update, osc_en, busy, done, err});
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_freq();
`ifdef OSC_FREQ_CNT_EN
        osc_run = 1'b1;
        go(MODE_HOLD, 8'd0, 8'd0, 8'd1, 16'd63);
        capture(200);
        vecs++;
        if (fv_cyc.size() != 3) begin
            errs++;
            $display("FAIL freq_valid_count: got %0d required 3", fv_cyc.size());
        end
        for (int i = 0; i < 3; i++) begin
            int gk, gv;
            gk = (i < fv_cyc.size()) ? fv_cyc[i] : -1;
            gv = (i < fv_val.size()) ? fv_val[i] : -1;
            vecs++;
            if (gk != 64 * (i + 1) || gv < 7 || gv > 9) begin
                errs++;
                $display("FAIL freq%0d: got %0d@%0d required 8+/-1@%0d", i, gv, gk, 64 * (i + 1));
            end
        end
        osc_run = 1'b0;
`else
        osc_run = 1'b1;
        go(MODE_HOLD, 8'd0, 8'd0, 8'd1, 16'd63);
        capture(70);
        vecs++;
        if (fv_cyc.size() != 0 || freq_cnt !== 16'd0) begin
            errs++;
            $display("FAIL freq_disabled: got %0d valids cnt=%0d required 0 0", fv_cyc.size(), freq_cnt);
        end
        osc_run = 1'b0;
`endif
        halt();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_ramp_clamp();
        test_triangle_stop();
        test_toggle_hold();
        test_reject();
        test_ena_reset();
        test_freq();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
